// File: rtl/gcd_share_ctrl_if.sv
// gcd_share_ctrl_if
// Bundles the requester-side and engine-side signals of the GCD sharing
// controller. The controller connects through the slave modport. The
// requesters and the engine (or a bench standing in for them) connect
// through the master modport.
//
// Requester side:
//   req      N    per-requester request level, held until own ack
//   req_a    N*W  operand a, requester i at [i*W +: W]
//   req_b    N*W  operand b, same packing
//   ack      N    one-hot single-cycle result strobe
//   res_gcd  W    result, valid while |ack
//   res_err  1    watchdog abort flag, valid while |ack
//   res_id   ID_W index of the acked requester, valid while |ack
//   busy     1    controller not idle
// Engine side:
//   eng_start 1   single-cycle start pulse
//   eng_a     W   operand a, held for the whole engine job
//   eng_b     W   operand b, held for the whole engine job
//   eng_done  1   result strobe; eng_gcd is valid in the same cycle
//   eng_gcd   W   engine result
interface gcd_share_ctrl_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    ack;
    logic [W-1:0]    res_gcd;
    logic            res_err;
    logic [ID_W-1:0] res_id;
    logic            busy;

    logic            eng_start;
    logic [W-1:0]    eng_a;
    logic [W-1:0]    eng_b;
    logic            eng_done;
    logic [W-1:0]    eng_gcd;

    modport slave (
        input  req, req_a, req_b, eng_done, eng_gcd,
        output ack, res_gcd, res_err, res_id, busy, eng_start, eng_a, eng_b
    );

    modport master (
        output req, req_a, req_b, eng_done, eng_gcd,
        input  ack, res_gcd, res_err, res_id, busy, eng_start, eng_a, eng_b
    );
endinterface

// File: rtl/gcd_share_ctrl.sv
// gcd_share_ctrl
// Round-robin scheduler that shares one GCD engine between N requesters.
// A granted requester's operands are latched. If either operand is zero,
// the result (a|b) is produced locally. Otherwise the engine is started
// once and its done is awaited under a watchdog. The result is returned
// with a one-cycle one-hot ack. All outputs are registered.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  gcd_share_ctrl_if slave modport (requester and engine signals)
//
// Parameters:
//   N        number of requesters (2..8)
//   W        operand/result width
//   TIMEOUT  maximum WAIT cycles before abort (>= 2)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no job; arbitrate req from rr_ptr onwards
// ISSUE | eng_start high for this cycle; watchdog loaded
// WAIT  | waiting for eng_done; abort with err when watchdog expires
// RESP  | ack[id] and result valid for this cycle; advance rr_ptr
module gcd_share_ctrl #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    gcd_share_ctrl_if.slave   bus
);
    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cur_id;
    logic [TMR_W-1:0] timer;

    logic            gnt_found;
    logic            gnt_zero;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] scan;
    logic [W-1:0]    gnt_a;
    logic [W-1:0]    gnt_b;
    logic            wd_expired;

    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        if (int'(i) >= N - 1) begin
            return '0;
        end
        return i + ID_W'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Rotating priority scan: the first requester at or after rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = rr_ptr;
        gnt_a     = '0;
        gnt_b     = '0;
        scan      = rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (!gnt_found && bus.req[scan]) begin
                gnt_found = 1'b1;
                gnt_id    = scan;
                gnt_a     = bus.req_a[int'(scan)*W +: W];
                gnt_b     = bus.req_b[int'(scan)*W +: W];
            end
            scan = next_idx(scan);
        end
    end

    assign gnt_zero = (gnt_a == '0) || (gnt_b == '0);

    // The watchdog counts down from TIMEOUT-1, so expiry on the terminal
    // count gives exactly TIMEOUT cycles in WAIT.
    assign wd_expired = (timer == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (gnt_found) begin
                    state_next = gnt_zero ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (bus.eng_done || wd_expired) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. ack/eng_start default low so they
    // can only ever be single-cycle pulses. eng_done is only examined in
    // WAIT, so an early done in ISSUE or a late one after abort is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            cur_id        <= '0;
            timer         <= '0;
            bus.ack       <= '0;
            bus.res_gcd   <= '0;
            bus.res_err   <= 1'b0;
            bus.res_id    <= '0;
            bus.busy      <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_a     <= '0;
            bus.eng_b     <= '0;
        end else begin
            bus.ack       <= '0;
            bus.eng_start <= 1'b0;
            bus.busy      <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        cur_id <= gnt_id;
                        if (gnt_zero) begin
                            bus.ack     <= onehot(gnt_id);
                            bus.res_id  <= gnt_id;
                            bus.res_gcd <= gnt_a | gnt_b;
                            bus.res_err <= 1'b0;
                        end else begin
                            bus.eng_a     <= gnt_a;
                            bus.eng_b     <= gnt_b;
                            bus.eng_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    timer <= TMR_LOAD;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        bus.ack     <= onehot(cur_id);
                        bus.res_id  <= cur_id;
                        bus.res_gcd <= bus.eng_gcd;
                        bus.res_err <= 1'b0;
                    end else if (wd_expired) begin
                        bus.ack     <= onehot(cur_id);
                        bus.res_id  <= cur_id;
                        bus.res_gcd <= '0;
                        bus.res_err <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                RESP: begin
                    rr_ptr      <= next_idx(cur_id);
                    bus.res_gcd <= '0;
                    bus.res_err <= 1'b0;
                    bus.res_id  <= '0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_share_ctrl.sv
// Bench for gcd_share_ctrl: directed scenarios with literal expectations,
// followed by randomized traffic. A job-level model predicts, from the
// sampled requests, the grant order, the result and the ack cycle of
// every job.
module tb_gcd_share_ctrl;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 8;

    logic clk;
    logic rst;

    gcd_share_ctrl_if #(.N(N), .W(W)) bus ();

    gcd_share_ctrl #(.N(N), .W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine latency (cycles from start to done) derived from the operands.
    // It spans 1..TO, so a done on the very last WAIT cycle is exercised.
    function automatic int lat_of(input int a, input int b);
        return ((a + b) % TO) + 1;
    endfunction

    // eng_mode: 0 normal, 1 never done, 2 done only after the watchdog fired
    int eng_mode;
    int op_a [N];
    int op_b [N];

    // ---------------- engine stand-in ----------------
    int eng_cnt;
    int eng_pend;
    always @(negedge clk) begin
        if (rst) begin
            eng_cnt      = 0;
            eng_pend     = 0;
            bus.eng_done = 1'b0;
            bus.eng_gcd  = '0;
        end else begin
            bus.eng_done = 1'b0;
            bus.eng_gcd  = W'($urandom);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_gcd  = W'(eng_pend);
                end
            end
            if (bus.eng_start) begin
                eng_pend = gcd_ref(int'(bus.eng_a), int'(bus.eng_b));
                case (eng_mode)
                    1:       eng_cnt = 0;
                    2:       eng_cnt = TO + 3;
                    default: eng_cnt = lat_of(int'(bus.eng_a), int'(bus.eng_b));
                endcase
            end
        end
    end

    // ---------------- job-level model and compare ----------------
    int           cyc = 0;
    int           n_starts = 0;
    int           m_rr = 0;
    logic         busy_prev = 1'b0;
    logic [N-1:0] prev_req = '0;
    bit           job_active = 0;
    bit           job_zero;
    int           job_id, job_a, job_b, job_gcd, job_err;
    int           job_s_cyc, job_ack_cyc, job_starts;

    always @(negedge clk) begin
        if (rst) begin
            job_active = 0;
            m_rr       = 0;
            busy_prev  = 1'b0;
            prev_req   = bus.req;
        end else begin
            cyc++;
            if (job_active) begin
                chk("busy_held", bus.busy, 1);
            end
            if (bus.busy && !busy_prev) begin
                chk("grant_overlap", job_active, 0);
                if (prev_req == '0) begin
                    chk("grant_without_req", bus.busy, 0);
                end else begin
                    job_id = -1;
                    for (int k = 0; k < N; k++) begin
                        if (job_id < 0 && prev_req[(m_rr + k) % N]) begin
                            job_id = (m_rr + k) % N;
                        end
                    end
                    job_a      = op_a[job_id];
                    job_b      = op_b[job_id];
                    job_zero   = (job_a == 0) || (job_b == 0);
                    job_s_cyc  = cyc;
                    job_starts = 0;
                    if (job_zero) begin
                        job_gcd     = job_a | job_b;
                        job_err     = 0;
                        job_ack_cyc = cyc;
                    end else if (eng_mode == 0) begin
                        job_gcd     = gcd_ref(job_a, job_b);
                        job_err     = 0;
                        job_ack_cyc = cyc + lat_of(job_a, job_b) + 1;
                    end else begin
                        job_gcd     = 0;
                        job_err     = 1;
                        job_ack_cyc = cyc + TO + 1;
                    end
                    job_active = 1;
                end
            end
            if (bus.eng_start) begin
                n_starts++;
                if (job_active && !job_zero && cyc == job_s_cyc) begin
                    job_starts++;
                    chk("eng_a_issue", bus.eng_a, job_a);
                    chk("eng_b_issue", bus.eng_b, job_b);
                end else begin
                    chk("start_unexpected", bus.eng_start, 0);
                end
            end
            if (job_active && !job_zero && cyc > job_s_cyc && cyc < job_ack_cyc) begin
                chk("eng_a_held", bus.eng_a, job_a);
                chk("eng_b_held", bus.eng_b, job_b);
            end
            if (bus.ack != '0 || (job_active && cyc == job_ack_cyc)) begin
                if (!job_active) begin
                    chk("ack_unexpected", bus.ack, 0);
                end else begin
                    chk("ack_vec", bus.ack, N'(1) << job_id);
                    chk("ack_cycle", cyc, job_ack_cyc);
                    if (bus.ack != '0) begin
                        chk("res_id", bus.res_id, job_id);
                        chk("res_gcd", bus.res_gcd, job_gcd);
                        chk("res_err", bus.res_err, job_err);
                        chk("starts_per_job", job_starts, job_zero ? 0 : 1);
                    end
                    m_rr       = (job_id + 1) % N;
                    job_active = 0;
                end
            end
            prev_req  = bus.req;
            busy_prev = bus.busy;
        end
    end

    // ---------------- requester-side helpers ----------------
    task automatic tick();
        logic [N-1:0] ack_prev;
        ack_prev = bus.ack;
        @(posedge clk);
        #1;
        bus.req = bus.req & ~ack_prev;
    endtask

    task automatic raise(input int i, input int a, input int b);
        op_a[i] = a;
        op_b[i] = b;
        bus.req_a[i*W +: W] = W'(a);
        bus.req_b[i*W +: W] = W'(b);
        bus.req[i] = 1'b1;
    endtask

    // n counts cycles with the raise cycle as 1; the ack cycle is included.
    task automatic wait_ack(input string name, input int budget, output int n,
                            output logic [N-1:0] av, output int id, output int g,
                            output int e);
        bit ok;
        ok = 0; n = 1; av = '0; id = -1; g = -1; e = -1;
        for (int k = 0; k < budget; k++) begin
            if (bus.ack != '0) begin
                ok = 1;
                av = bus.ack;
                id = int'(bus.res_id);
                g  = int'(bus.res_gcd);
                e  = int'(bus.res_err);
                break;
            end
            tick();
            n++;
        end
        if (!ok) begin
            chk({name, "_ack_timeout"}, 0, 1);
        end
        tick();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    int           n, id, g, e, s0, r, f;
    logic [N-1:0] av;
    bit           drained;

    initial begin
        rst       = 1'b1;
        eng_mode  = 0;
        bus.req   = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 0;
            op_b[i] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_eng_start", bus.eng_start, 0);
        chk("rst_eng_a", bus.eng_a, 0);
        chk("rst_eng_b", bus.eng_b, 0);
        chk("rst_res_gcd", bus.res_gcd, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_res_id", bus.res_id, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // basic: (6,12), engine done 3 cycles after start
        s0 = n_starts;
        raise(0, 6, 12);
        wait_ack("basic", 40, n, av, id, g, e);
        chk("basic_ack", av, 4'b0001);
        chk("basic_gcd", g, 6);
        chk("basic_err", e, 0);
        chk("basic_id", id, 0);
        chk("basic_latency", n, 6);
        chk("basic_starts", n_starts - s0, 1);

        // round robin from rr_ptr = 0
        pulse_reset();
        raise(0, 75, 90);
        raise(1, 6, 12);
        raise(3, 14, 21);
        wait_ack("rr1", 40, n, av, id, g, e);
        chk("rr1_id", id, 0);
        chk("rr1_gcd", g, 15);
        wait_ack("rr2", 40, n, av, id, g, e);
        chk("rr2_id", id, 1);
        chk("rr2_gcd", g, 6);
        wait_ack("rr3", 40, n, av, id, g, e);
        chk("rr3_id", id, 3);
        chk("rr3_gcd", g, 7);
        raise(0, 8, 12);
        raise(1, 9, 27);
        wait_ack("rr4", 40, n, av, id, g, e);
        chk("rr4_id", id, 0);
        chk("rr4_gcd", g, 4);
        wait_ack("rr5", 40, n, av, id, g, e);
        chk("rr5_id", id, 1);
        chk("rr5_gcd", g, 9);

        // zero-operand bypass
        s0 = n_starts;
        raise(2, 0, 9);
        wait_ack("zero", 40, n, av, id, g, e);
        chk("zero_ack", av, 4'b0100);
        chk("zero_gcd", g, 9);
        chk("zero_err", e, 0);
        chk("zero_latency", n, 2);
        raise(3, 0, 0);
        wait_ack("zero00", 40, n, av, id, g, e);
        chk("zero00_id", id, 3);
        chk("zero00_gcd", g, 0);
        chk("zero00_err", e, 0);
        chk("zero_starts", n_starts - s0, 0);

        // watchdog: engine never answers
        eng_mode = 1;
        s0 = n_starts;
        raise(0, 9, 6);
        wait_ack("wd", 60, n, av, id, g, e);
        chk("wd_err", e, 1);
        chk("wd_gcd", g, 0);
        chk("wd_latency", n, TO + 3);
        chk("wd_starts", n_starts - s0, 1);

        // late done after abort must not produce a second ack
        eng_mode = 2;
        raise(0, 9, 6);
        wait_ack("late", 60, n, av, id, g, e);
        chk("late_err", e, 1);
        chk("late_gcd", g, 0);
        eng_mode = 0;
        for (int k = 0; k < 6; k++) begin
            chk("late_no_ack", bus.ack, 0);
            tick();
        end

        // asynchronous reset while waiting on the engine
        eng_mode = 1;
        raise(1, 75, 90);
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ack", bus.ack, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_eng_start", bus.eng_start, 0);
        chk("mid_rst_eng_a", bus.eng_a, 0);
        chk("mid_rst_eng_b", bus.eng_b, 0);
        chk("mid_rst_res_gcd", bus.res_gcd, 0);
        chk("mid_rst_res_err", bus.res_err, 0);
        chk("mid_rst_res_id", bus.res_id, 0);
        chk("mid_rst_rr_ptr", dut.rr_ptr, 0);
        eng_mode = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        wait_ack("after_rst", 40, n, av, id, g, e);
        chk("after_rst_id", id, 1);
        chk("after_rst_gcd", g, 15);
        chk("after_rst_err", e, 0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 19);
            eng_mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    f = $urandom_range(1, 12);
                    raise(i, f * $urandom_range(0, 15), f * $urandom_range(0, 15));
                end
            end
            tick();
        end

        eng_mode = 0;
        drained = 0;
        for (int k = 0; k < 600; k++) begin
            if (bus.req == '0 && !bus.busy) begin
                drained = 1;
                break;
            end
            tick();
        end
        chk("drain_all_served", drained, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gcd_share_ctrl.md
Name: gcd_share_ctrl

Overview:
Round-robin scheduler that shares one Greatest_Common_Divisor engine (start/a/b in, done/gcd out) between N requesters. It latches a granted requester's operands and pulses the engine's start. It then waits for done, with a watchdog, and returns the result to the requester with a one-cycle ack. Zero operands are resolved locally without using the engine.

Parameters:
N, 4, number of requesters (2..8)
W, 16, operand/result width
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
req  in  N  per-requester request level; held high until own ack
req_a  in  N*W  operand a, requester i at bits [i*W +: W]
req_b  in  N*W  operand b, same packing
ack  out  N  one-hot, one-cycle pulse: result for requester i valid
res_gcd  out  W  result; valid only while |ack
res_err  out  1  1 = watchdog abort (res_gcd=0); valid only while |ack
res_id  out  clog2(N) (min 1)  index of acked requester; valid while |ack
busy  out  1  high in every state except IDLE
eng_start  out  1  one-cycle start pulse to engine
eng_a  out  W  engine operand a; held stable from ISSUE until leaving WAIT
eng_b  out  W  engine operand b; same
eng_done  in  1  engine done; eng_gcd valid in the same cycle
eng_gcd  in  W  engine result

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr_ptr=0, timer=0.
  - ack, res_gcd, res_err, res_id, busy, eng_start, eng_a, eng_b all 0.
  - An in-flight job is dropped with no ack. The requester keeps req high and is re-arbitrated after reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req==0, stay.
  - Otherwise grant the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N.
  - Latch id=i, a=req_a[i], b=req_b[i].
  - If a==0 or b==0: result=a|b (0,0 gives 0), err=0, go to RESP.
  - Otherwise load eng_a/eng_b and go to ISSUE.
- ISSUE: eng_start=1 for exactly this cycle; timer=0; go to WAIT.
- WAIT:
  - If eng_done=1: capture eng_gcd, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: result=0, err=1, go to RESP.
  - Else timer++.
  - eng_done in the ISSUE cycle is ignored; engine done is defined as at least one cycle after start.
- RESP:
  - ack[id]=1, res_id=id, res_gcd/res_err valid for this cycle only.
  - rr_ptr=(id+1) mod N; go to IDLE.
- eng_done outside WAIT, including a late done after a timeout abort, is ignored.
- Requester rules:
  - req[i] and operands must be stable from assertion until ack[i].
  - req[i] is deasserted at the edge where ack[i] is sampled high.
  - Operand changes while req is high are undefined.
- req is sampled only in IDLE. Requests raised during a job wait, with no loss.
- Simultaneous requests are served one per job in strict rotation. Worst-case wait for any requester is N-1 jobs.
- Latency from grant edge to ack:
  - Zero operand: ack 1 cycle after the grant cycle (IDLE→RESP).
  - Engine path: ISSUE + k WAIT cycles + RESP, where k = cycles to eng_done.
- The engine is never started while a job is outstanding. eng_start count equals the number of non-zero jobs issued.

Test Plan:
- Basic: N=4, req[0]=1, a=6, b=12, engine model with done 3 cycles after start → one eng_start pulse with eng_a=6/eng_b=12, then ack=4'b0001, res_gcd=6, res_err=0, res_id=0.
- Round-robin: req=4'b1011 together, ops (75,90)/(6,12)/-/(14,21) → acks in order id 0,1,3 with 15, 6, 7. Then req[0] and req[1] re-raised while rr_ptr=0 → id 0 before id 1.
- Zero bypass: req[2] with a=0, b=9 → ack[2] 2 cycles after req, res_gcd=9, eng_start never asserted. (0,0) → res_gcd=0, res_err=0.
- Watchdog: TIMEOUT=8, engine never asserts done → ack with res_err=1, res_gcd=0, eng_start seen exactly once. A late eng_done pulse afterwards causes no ack.
- Reset mid-operation: rst pulse during WAIT → all outputs 0 immediately (asynchronous), rr_ptr=0. After release, the still-pending req[1] (a=75, b=90) is re-issued → res_gcd=15.
